// File: rtl/lcd_timing_gen_if.sv
// FIFO-side bundle for lcd_timing_gen.
// The timing generator is the master: it issues the read strobe and the
// frame-start marker, and it receives the FIFO's registered pixel word.
//   active_video_o : one-cycle read strobe per visible pixel
//   frame_start_o  : strobe of pixel (0,0)
//   lcd_dat_i      : FIFO output word, valid the cycle after the strobe
interface lcd_timing_gen_if #(
  parameter int unsigned DATA_WIDTH = 18
);
  logic                  active_video_o;
  logic                  frame_start_o;
  logic [DATA_WIDTH-1:0] lcd_dat_i;

  modport master (
    output active_video_o,
    output frame_start_o,
    input  lcd_dat_i
  );

  modport slave (
    input  active_video_o,
    input  frame_start_o,
    output lcd_dat_i
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// Pixel timing generator for a parallel RGB LCD panel.
// Produces pixel clock, hsync, vsync and DE, reads one word per visible pixel
// from the upstream FIFO and presents it aligned with the sync/DE outputs.
// Ports:
//   aclk_i     : clock
//   rst_i      : synchronous active-high reset
//   enable_i   : run request, honoured at frame boundaries only
//   fifo_if    : FIFO side (read strobe, frame start, pixel word in)
//   lcd_pclk_o : panel pixel clock (panel samples on its rising edge)
//   lcd_hsync_o, lcd_vsync_o, lcd_de_o, lcd_dat_o : panel pins
module lcd_timing_gen #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned PCLK_DIV   = 4,
  parameter int unsigned H_ACTIVE   = 480,
  parameter int unsigned H_FP       = 8,
  parameter int unsigned H_SYNC     = 4,
  parameter int unsigned H_BP       = 43,
  parameter int unsigned V_ACTIVE   = 272,
  parameter int unsigned V_FP       = 4,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 12,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0
) (
  input  logic                  aclk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  lcd_timing_gen_if.master      fifo_if,
  output logic                  lcd_pclk_o,
  output logic                  lcd_hsync_o,
  output logic                  lcd_vsync_o,
  output logic                  lcd_de_o,
  output logic [DATA_WIDTH-1:0] lcd_dat_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned DIV_W    = $clog2(PCLK_DIV);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [VW-1:0]      vcnt_q, vcnt_d;

  logic run_c, tick_c, visible_c, hs_act_c, vs_act_c, frame_last_c, strobe_c;

  // First pipeline stage: region decode and divider phase of the current cycle
  logic               run1_q, tick1_q, vis1_q, hs1_q, vs1_q;
  logic [DIV_W-1:0]   div1_q;

  // Second stage: panel pin registers
  logic                  pclk_q, hsync_q, vsync_q, de_q;
  logic [DATA_WIDTH-1:0] dat_q;

  // State and raster counters
  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // Next-state, raster advance and region decode
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    run_c        = (state_q == RUN);
    tick_c       = run_c && (div_q == '0);
    visible_c    = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
    hs_act_c     = (32'(hcnt_q) >= HS_START) && (32'(hcnt_q) < HS_END);
    vs_act_c     = (32'(vcnt_q) >= VS_START) && (32'(vcnt_q) < VS_END);
    frame_last_c = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

    unique case (state_q)
      IDLE: begin
        div_d  = '0;
        hcnt_d = '0;
        vcnt_d = '0;
        if (enable_i) state_d = RUN;
      end
      RUN: begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        if (tick_c) begin
          if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
          // A dropped enable only takes effect once the frame is complete
          if (frame_last_c && !enable_i) begin
            state_d = IDLE;
            div_d   = '0;
            hcnt_d  = '0;
            vcnt_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are suppressed in the reset cycle itself
  assign strobe_c                = tick_c && visible_c && !rst_i;
  assign fifo_if.active_video_o  = strobe_c;
  assign fifo_if.frame_start_o   = strobe_c && (hcnt_q == '0) && (vcnt_q == '0);

  // Two-stage alignment: stage 1 tracks the strobe cycle, stage 2 loads the
  // pins together with the FIFO word that arrives one cycle after the strobe.
  always_ff @(posedge aclk_i) begin
    if (rst_i) begin
      run1_q  <= 1'b0;
      tick1_q <= 1'b0;
      vis1_q  <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      div1_q  <= '0;
      pclk_q  <= 1'b0;
      de_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      dat_q   <= '0;
    end else begin
      run1_q  <= run_c;
      tick1_q <= tick_c;
      vis1_q  <= visible_c;
      hs1_q   <= hs_act_c;
      vs1_q   <= vs_act_c;
      div1_q  <= div_q;
      // Falls with each data update, rises mid-pixel
      pclk_q  <= run1_q && (32'(div1_q) >= PCLK_DIV / 2);
      if (tick1_q) begin
        de_q    <= vis1_q;
        hsync_q <= hs1_q ? HS_POL : ~HS_POL;
        vsync_q <= vs1_q ? VS_POL : ~VS_POL;
        dat_q   <= vis1_q ? fifo_if.lcd_dat_i : '0;
      end else if (!run1_q) begin
        // Back in IDLE: return the pins to their idle levels
        de_q    <= 1'b0;
        hsync_q <= ~HS_POL;
        vsync_q <= ~VS_POL;
        dat_q   <= '0;
      end
    end
  end

  assign lcd_pclk_o  = pclk_q;
  assign lcd_hsync_o = hsync_q;
  assign lcd_vsync_o = vsync_q;
  assign lcd_de_o    = de_q;
  assign lcd_dat_o   = dat_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen on a small raster (8x6 pixels, 4 aclk per pixel).
// A frame-arithmetic model predicts every output on every cycle; directed
// phases add literal expectations for counts, spacing and alignment.
module tb_lcd_timing_gen;

  localparam int unsigned DW = 18;
  localparam int unsigned PD = 4;
  localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT    = int'(HA + HF + HS + HB);
  localparam int VT    = int'(VA + VF + VS + VB);
  localparam int FRAME = HT * VT * int'(PD);

  logic          aclk     = 1'b0;
  logic          rst_i    = 1'b1;
  logic          enable_i = 1'b0;
  logic          pclk, hsync, vsync, de;
  logic [DW-1:0] dat;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int fifo_cnt = 0;

  // Model state: run flag and cycle offset since the first tick of the run
  bit m_run    = 1'b0;
  int m_k      = 0;
  int m_cnt    = 0;
  int m_word   = 0;
  bit rst_prev = 1'b1;
  bit h1_run   = 1'b0, h2_run = 1'b0;
  int h1_k     = 0,    h2_k   = 0;
  int h1_word  = 0,    h2_word = 0;

  lcd_timing_gen_if #(.DATA_WIDTH(DW)) fif ();

  lcd_timing_gen #(
    .DATA_WIDTH(DW), .PCLK_DIV(PD),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .aclk_i      (aclk),
    .rst_i       (rst_i),
    .enable_i    (enable_i),
    .fifo_if     (fif),
    .lcd_pclk_o  (pclk),
    .lcd_hsync_o (hsync),
    .lcd_vsync_o (vsync),
    .lcd_de_o    (de),
    .lcd_dat_o   (dat)
  );

  always #5 aclk = ~aclk;

  // FIFO stand-in: each read returns the running pixel index, registered
  always @(posedge aclk) begin
    if (fif.active_video_o) begin
      fif.lcd_dat_i <= DW'(fifo_cnt);
      fifo_cnt      <= fifo_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc_n, act, exp);
    end
  endtask

  // Predict this cycle's outputs from frame arithmetic, compare, then advance
  task automatic model_cycle();
    int kk, p, ph, h, v;
    int kk2, p2, ph2, hh, vv;
    bit eff, strobe, fs, vis2;
    int e_de, e_hs, e_vs, e_pclk, e_dat;
    kk  = m_k % FRAME;
    p   = kk / int'(PD);
    ph  = kk % int'(PD);
    h   = p % HT;
    v   = p / HT;
    eff = m_run && !rst_i;
    strobe = eff && (ph == 0) && (h < int'(HA)) && (v < int'(VA));
    fs     = strobe && (p == 0);
    if (strobe) begin
      m_word = m_cnt;
      m_cnt++;
    end
    chk("active_video", int'(fif.active_video_o), int'(strobe));
    chk("frame_start", int'(fif.frame_start_o), int'(fs));

    // Pins reflect the raster position two cycles back
    if (rst_prev || !h2_run) begin
      e_de = 0; e_hs = 1; e_vs = 1; e_pclk = 0; e_dat = 0;
    end else begin
      kk2  = h2_k % FRAME;
      p2   = kk2 / int'(PD);
      ph2  = kk2 % int'(PD);
      hh   = p2 % HT;
      vv   = p2 / HT;
      vis2 = (hh < int'(HA)) && (vv < int'(VA));
      e_de   = int'(vis2);
      e_hs   = (hh >= int'(HA + HF) && hh < int'(HA + HF + HS)) ? 0 : 1;
      e_vs   = (vv >= int'(VA + VF) && vv < int'(VA + VF + VS)) ? 0 : 1;
      e_pclk = (ph2 >= int'(PD / 2)) ? 1 : 0;
      e_dat  = vis2 ? h2_word : 0;
    end
    chk("lcd_de", int'(de), e_de);
    chk("lcd_hsync", int'(hsync), e_hs);
    chk("lcd_vsync", int'(vsync), e_vs);
    chk("lcd_pclk", int'(pclk), e_pclk);
    chk("lcd_dat", int'(dat), e_dat);

    h2_run = h1_run; h2_k = h1_k; h2_word = h1_word;
    h1_run = eff;    h1_k = m_k;  h1_word = m_word;
    rst_prev = rst_i;

    if (rst_i) m_run = 1'b0;
    else if (!m_run) begin
      if (enable_i) begin
        m_run = 1'b1;
        m_k   = 0;
      end
    end else if (kk == FRAME - int'(PD) && !enable_i) m_run = 1'b0;
    else m_k++;
  endtask

  // Drive one cycle's inputs after the falling edge, then check it
  task automatic cyc(input logic r, input logic e);
    @(negedge aclk);
    #1;
    rst_i    = r;
    enable_i = e;
    cyc_n++;
    #1;
    model_cycle();
  endtask

  initial begin
    int n, late, fs_n, de_n, hs_n, vs_n, en_cyc;
    int de_rise, hs_fall, pclk_rise, rst_cyc;
    bit fs_first, found, p_de, p_hs, p_pclk, en_r;
    logic [DW-1:0] p_dat;
    int st_t[$];
    int dvals[$];

    // Reset, then idle with enable low
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 1'b0);
      if (fif.active_video_o) n++;
    end
    chk("idle_strobes", n, 0);
    chk("idle_hsync", int'(hsync), 1);
    chk("idle_vsync", int'(vsync), 1);
    chk("idle_de", int'(de), 0);
    chk("idle_pclk", int'(pclk), 0);

    // One frame: enable for a single cycle
    cyc(1'b0, 1'b1);
    en_cyc = cyc_n;
    fs_n = 0; de_n = 0; hs_n = 0; vs_n = 0; fs_first = 1'b0;
    de_rise = -1; hs_fall = -1; pclk_rise = -1;
    p_de = 1'b0; p_hs = 1'b1; p_pclk = 1'b0; p_dat = '0;
    for (int i = 0; i < 260; i++) begin
      cyc(1'b0, 1'b0);
      if (fif.active_video_o) begin
        st_t.push_back(cyc_n);
        if (fif.frame_start_o && st_t.size() == 1) fs_first = 1'b1;
      end
      if (fif.frame_start_o) fs_n++;
      if (de) de_n++;
      if (!hsync) hs_n++;
      if (!vsync) vs_n++;
      if (de && !p_de && de_rise < 0) de_rise = cyc_n;
      if (!hsync && p_hs && hs_fall < 0) hs_fall = cyc_n;
      if (pclk && !p_pclk && pclk_rise < 0) pclk_rise = cyc_n;
      if (de && (!p_de || dat != p_dat)) dvals.push_back(int'(dat));
      p_de = de; p_hs = hsync; p_pclk = pclk; p_dat = dat;
    end
    chk("frame_strobes", st_t.size(), 12);
    chk("first_strobe_latency", (st_t.size() > 0) ? st_t[0] - en_cyc : -1, 1);
    chk("frame_start_count", fs_n, 1);
    chk("frame_start_on_first", int'(fs_first), 1);
    for (int i = 1; i < st_t.size(); i++)
      chk("strobe_gap", st_t[i] - st_t[i-1], (i % 4 == 0) ? 20 : 4);
    chk("de_cycles", de_n, 48);
    chk("first_de_latency", de_rise - en_cyc, 3);
    chk("data_after_strobe", (st_t.size() > 0) ? de_rise - st_t[0] : -1, 2);
    chk("pclk_rise_after_data", pclk_rise - de_rise, 2);
    chk("hsync_low_cycles", hs_n, 48);
    chk("hsync_offset", hs_fall - de_rise, 20);
    chk("vsync_low_cycles", vs_n, 32);
    chk("data_words", dvals.size(), 12);
    for (int i = 0; i < 4; i++)
      chk("line0_data", (i < dvals.size()) ? dvals[i] : -1, i);

    // Randomized enable toggling with rare resets
    en_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) en_r = ~en_r;
      cyc(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0, en_r);
    end

    // Enable dropped at pixel (2,1): frame still completes, then stays idle
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    en_r = 1'b1; n = 0; late = 0; found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      cyc(1'b0, en_r);
      if (fif.active_video_o) begin
        n++;
        if (i >= 250) late++;
        if (n == 7) begin
          en_r  = 1'b0;
          found = 1'b1;
        end
      end
    end
    chk("drop_point_reached", int'(found), 1);
    chk("drop_frame_strobes", n, 12);
    chk("strobes_after_stop", late, 0);

    // Reset for one cycle at pixel (1,1) while enabled
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    n = 0; found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      cyc(1'b0, 1'b1);
      if (fif.active_video_o) n++;
      if (n == 6) found = 1'b1;
    end
    chk("reset_point_reached", int'(found), 1);
    cyc(1'b1, 1'b1);
    rst_cyc = cyc_n;
    cyc(1'b0, 1'b1);
    chk("post_reset_de", int'(de), 0);
    chk("post_reset_pclk", int'(pclk), 0);
    chk("post_reset_hsync", int'(hsync), 1);
    chk("post_reset_vsync", int'(vsync), 1);
    chk("post_reset_dat", int'(dat), 0);
    chk("release_frame_start", int'(fif.frame_start_o), 0);
    cyc(1'b0, 1'b0);
    chk("restart_frame_start", int'(fif.frame_start_o), 1);
    chk("restart_cycle", cyc_n - rst_cyc, 2);
    n = int'(fif.active_video_o);
    for (int i = 0; i < 230; i++) begin
      cyc(1'b0, 1'b0);
      if (fif.active_video_o) n++;
    end
    chk("restart_frame_strobes", n, 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
